neuron_mac: RTL and testbench
=============================

# neuron_mac

Sequential multiply-accumulate neuron core that sits directly upstream of the sigmoid/tanh activation LUT. It takes a streamed vector of signed Q16.16 input/weight pairs, accumulates their products, and adds a per-neuron bias. It then saturates the sum and presents it as the N-bit Q16.16 `phase` word that the activation stage consumes, using a valid/ready handshake on both sides.

## Interface
- `N`, 32, data word width (signed fixed point)
- `Q`, 16, fractional bits
- `ACC_W`, 64, accumulator width (signed, Q fractional bits)
- `CNT_W`, 10, beat-counter width; max vector length 2^CNT_W
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`
- `in_x`  in  N  signed Q16.16 activation
- `in_w`  in  N  signed Q16.16 weight
- `in_last`  in  1  final beat of vector
- `bias`  in  N  signed Q16.16 bias, sampled on first accepted beat of a vector
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accept
- `out_phase`  out  N  signed Q16.16 result, feeds activation `phase`
- `out_ovf`  out  1  result was saturated
- `out_len_err`  out  1  vector forcibly terminated at max length

## Operation
- FSM states: IDLE, ACC, DRAIN, FIN, OUT.
- IDLE and ACC: `in_ready`=1. On the first accepted beat: clear acc, latch `bias`, clear beat count, go to ACC.
- Each accepted beat: product = `in_x` * `in_w`, full 2N-bit signed. Shift it arithmetically right by Q (truncate toward −inf), sign-extend to ACC_W and register it in the product stage. It is added to acc one cycle later. Acc wraps modulo 2^ACC_W.
- Accepting a beat with `in_last`=1 moves the FSM to DRAIN. The beat that brings the count to 2^CNT_W also moves to DRAIN, whatever `in_last` is, and sets the `out_len_err` flag.
- DRAIN: `in_ready`=0. The last product is added to acc. Go to FIN.
- FIN: `in_ready`=0. sum = acc + sign-extended bias. Saturate per Configuration and register the result into `out_phase`/`out_ovf`/`out_len_err`. Go to OUT.
- OUT: `out_valid`=1, `in_ready`=0, and the outputs are held stable. On `out_ready` go to IDLE and drop `out_valid`.
- Gaps (`in_valid`=0) between beats in ACC are allowed. Acc holds, and the product stage inserts zero.
- Single-beat vectors (`in_last` on the first beat) are legal.

## Timing
- Reset values:
  - state IDLE
  - acc = 0
  - product reg = 0
  - `out_valid`=0
  - `out_phase`=0
  - `out_ovf`=0
  - `out_len_err`=0
  - `in_ready`=0 while `rst`=1
- Latency: last beat accepted in cycle T gives `out_valid`=1 in cycle T+3 (DRAIN at T+1, FIN at T+2).
- Throughput: a new vector can be accepted from the cycle after the output handshake. The minimum gap between vectors is 4 cycles, plus any stall.
- Reset mid-vector or mid-OUT discards all partial state. The next vector starts clean.
- `out_ready` asserted without `out_valid` has no effect.

## Configuration
- `NEURON_MAC_SAT_EN` defined:
  - sum > 2^(N−1)−1 gives 0x7FFFFFFF and `out_ovf`=1.
  - sum < −2^(N−1) gives 0x80000000 and `out_ovf`=1.
  - Otherwise `out_phase` = sum[N−1:0].
- Undefined: `out_phase` = sum[N−1:0] (wrap), and `out_ovf` is tied to 0.

## Structure
- Package `neuron_pkg` holds:
  - the FSM state enum
  - Q-format constants: `FX_ONE` = 1<<Q
  - saturation limits `FX_MAX`/`FX_MIN`
- Sub-module `fx_mul`: signed N×N multiply, arithmetic shift by Q, registered output with enable. It is reused by later layers.

## Test plan
- Single beat, x=0x00010000, w=0x00020000, bias=0x00008000 -> `out_phase`=0x00028000 at T+3, `out_ovf`=0.
- 4 beats, x=0x00008000, w=0xFFFF0000, bias=0 -> `out_phase`=0xFFFE0000 (−2.0).
- Truncation: x=0xFFFF8000, w=0x00000001, bias=0 -> `out_phase`=0xFFFFFFFF.
- Overflow: 2 beats, x=w=0x7FFF0000 -> with macro, 0x7FFFFFFF and `out_ovf`=1; without macro, the low 32 bits of the sum and `out_ovf`=0.
- Backpressure and gaps: random `in_valid` gaps give results identical to the gapless run. With `out_ready` low for 5 cycles, `out_phase` is held and `in_ready`=0; the next vector is accepted only after the handshake.
- Reset and length: `rst` pulsed after 2 beats of vector A, then vector B (1 beat, 1.0×1.0) -> 0x00010000. A run of 1024 beats without `in_last` -> `out_len_err`=1.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared Q-format constants and FSM encoding for the neuron MAC datapath.
// Consumed by neuron_mac, fx_mul and later layers that reuse the same number format.
package neuron_pkg;

   localparam int FX_N = 32;
   localparam int FX_Q = 16;

   localparam logic [FX_N-1:0] FX_ONE = FX_N'(1) << FX_Q;
   localparam logic [FX_N-1:0] FX_MAX = {1'b0, {(FX_N-1){1'b1}}};
   localparam logic [FX_N-1:0] FX_MIN = {1'b1, {(FX_N-1){1'b0}}};

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_ACC   = 3'd1;
   localparam state_t ST_DRAIN = 3'd2;
   localparam state_t ST_FIN   = 3'd3;
   localparam state_t ST_OUT   = 3'd4;

endpackage

// File: rtl/fx_mul.sv
// Signed fixed-point multiply: full-width product, arithmetic shift right by Q, registered.
// Latency 1 cycle; en low registers zero so an idle cycle contributes nothing downstream.
// No backpressure: the caller gates en with its own handshake.
module fx_mul
   import neuron_pkg::*;
#(
   parameter int N   = FX_N,
   parameter int Q   = FX_Q,
   parameter int P_W = 2*FX_N
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [P_W-1:0] p
);

   logic signed [2*N-1:0] full;
   logic signed [2*N-1:0] scaled;

   assign full   = (2*N)'($signed(a)) * (2*N)'($signed(b));
   // Arithmetic shift truncates toward minus infinity.
   assign scaled = full >>> Q;

   always_ff @(posedge clk) begin
      if (rst)
         p <= '0;
      else if (en)
         p <= P_W'(scaled);
      else
         p <= '0;
   end

endmodule

// File: rtl/neuron_mac.sv
// MAC neuron: streams x*w beats into an accumulator, adds latched bias, emits Q16.16 phase.
// Latency: last beat accepted in cycle T gives out_valid in T+3; NEURON_MAC_SAT_EN enables saturation.
// Backpressure: in_ready low from DRAIN until the output handshake; OUT holds until out_ready.
module neuron_mac
   import neuron_pkg::*;
#(
   parameter int N     = FX_N,
   parameter int Q     = FX_Q,
   parameter int ACC_W = 64,
   parameter int CNT_W = 10
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_x,
   input  logic [N-1:0] in_w,
   input  logic         in_last,
   input  logic [N-1:0] bias,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_phase,
   output logic         out_ovf,
   output logic         out_len_err
);

   state_t                   state;
   logic signed [ACC_W-1:0]  acc;
   logic        [ACC_W-1:0]  prod_q;
   logic        [N-1:0]      bias_q;
   logic        [CNT_W-1:0]  cnt;
   logic                     len_err_q;
   logic                     accept;
   logic                     at_max;

   assign in_ready  = !rst && (state == ST_IDLE || state == ST_ACC);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == ST_OUT);
   // cnt holds beats already taken, so all-ones means this beat is number 2^CNT_W.
   assign at_max    = (state == ST_ACC) && (cnt == {CNT_W{1'b1}});

   fx_mul #(.N(N), .Q(Q), .P_W(ACC_W)) u_mul (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .a   (in_x),
      .b   (in_w),
      .p   (prod_q)
   );

`ifdef NEURON_MAC_SAT_EN
   localparam logic signed [ACC_W-1:0] SUM_MAX = (ACC_W'(1) <<< (N-1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] SUM_MIN = -(ACC_W'(1) <<< (N-1));
   logic signed [ACC_W-1:0] sum;
   assign sum = acc + ACC_W'($signed(bias_q));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         acc         <= '0;
         bias_q      <= '0;
         cnt         <= '0;
         len_err_q   <= 1'b0;
         out_phase   <= '0;
         out_ovf     <= 1'b0;
         out_len_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  acc       <= '0;
                  bias_q    <= bias;
                  cnt       <= CNT_W'(1);
                  len_err_q <= 1'b0;
                  state     <= in_last ? ST_DRAIN : ST_ACC;
               end
            end
            ST_ACC: begin
               // The product register carries zero on gap cycles, so add unconditionally.
               acc <= acc + prod_q;
               if (accept) begin
                  cnt <= cnt + CNT_W'(1);
                  if (in_last || at_max)
                     state <= ST_DRAIN;
                  if (at_max)
                     len_err_q <= 1'b1;
               end
            end
            ST_DRAIN: begin
               acc   <= acc + prod_q;
               state <= ST_FIN;
            end
            ST_FIN: begin
`ifdef NEURON_MAC_SAT_EN
               if (sum > SUM_MAX) begin
                  out_phase <= SUM_MAX[N-1:0];
                  out_ovf   <= 1'b1;
               end else if (sum < SUM_MIN) begin
                  out_phase <= SUM_MIN[N-1:0];
                  out_ovf   <= 1'b1;
               end else begin
                  out_phase <= sum[N-1:0];
                  out_ovf   <= 1'b0;
               end
`else
               out_phase <= acc[N-1:0] + bias_q;
               out_ovf   <= 1'b0;
`endif
               out_len_err <= len_err_q;
               state       <= ST_OUT;
            end
            ST_OUT: begin
               if (out_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: expected results queued when a vector is driven, checked at output.
`timescale 1ns/1ps
module tb_neuron_mac;
   import neuron_pkg::*;

   typedef struct packed {
      logic [31:0] phase;
      logic        ovf;
      logic        len;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_x = '0;
   logic [31:0] in_w = '0;
   logic        in_last = 1'b0;
   logic [31:0] bias = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_phase;
   logic        out_ovf;
   logic        out_len_err;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] vx[0:1023];
   logic [31:0] vw[0:1023];

   always #5 clk = ~clk;

   neuron_mac #(.N(32), .Q(16), .ACC_W(64), .CNT_W(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_x        (in_x),
      .in_w        (in_w),
      .in_last     (in_last),
      .bias        (bias),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_phase   (out_phase),
      .out_ovf     (out_ovf),
      .out_len_err (out_len_err)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives n beats (optionally with random gaps) and queues the expected result.
   task automatic send_vec(input int n, input logic [31:0] b, input int gap_pct,
                           input logic has_last, input logic use_lit, input exp_t lit);
      logic signed [63:0] am;
      logic signed [63:0] pr;
      logic signed [63:0] sum;
      exp_t e;
      int   tries;
      am = 64'sd0;
      for (int i = 0; i < n; i++) begin
         pr = $signed(vx[i]) * $signed(vw[i]);
         am = am + (pr >>> 16);
      end
      sum = am + {{32{b[31]}}, b};
`ifdef NEURON_MAC_SAT_EN
      if (sum > 64'sh000000007FFFFFFF) begin
         e.phase = FX_MAX; e.ovf = 1'b1;
      end else if (sum < $signed(64'hFFFFFFFF80000000)) begin
         e.phase = FX_MIN; e.ovf = 1'b1;
      end else begin
         e.phase = sum[31:0]; e.ovf = 1'b0;
      end
`else
      e.phase = sum[31:0];
      e.ovf   = 1'b0;
`endif
      e.len = (n == 1024);
      if (use_lit) e = lit;
      sb.push_back(e);

      for (int i = 0; i < n; i++) begin
         while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            step();
         end
         in_valid = 1'b1;
         in_x     = vx[i];
         in_w     = vw[i];
         in_last  = has_last && (i == n - 1);
         bias     = (i == 0) ? b : $urandom;
         tries    = 0;
         while (!in_ready && tries < 50) begin
            step();
            tries++;
         end
         if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: beat %0d in_ready=0 after %0d cycles, required 1", i, tries);
         end
         step();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_x     = '0;
      in_w     = '0;
   endtask

   task automatic collect(input string tag);
      exp_t e;
      int   n;
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s_valid: out_valid=%b after %0d cycles, required 1", tag, out_valid, n);
      end
      total++;
      if (out_phase !== e.phase) begin
         bad++;
         $display("FAIL %s_phase: got %h, required %h", tag, out_phase, e.phase);
      end
      total++;
      if (out_ovf !== e.ovf) begin
         bad++;
         $display("FAIL %s_ovf: got %b, required %b", tag, out_ovf, e.ovf);
      end
      total++;
      if (out_len_err !== e.len) begin
         bad++;
         $display("FAIL %s_len_err: got %b, required %b", tag, out_len_err, e.len);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL %s_drop: out_valid=%b after handshake, required 0", tag, out_valid);
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      step();
      step();
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
      total++;
      if (out_phase !== 32'h0) begin bad++; $display("FAIL rst_phase: got %h, required 0", out_phase); end
      total++;
      if ({out_ovf, out_len_err} !== 2'b00) begin
         bad++; $display("FAIL rst_flags: got %b%b, required 00", out_ovf, out_len_err);
      end
      in_valid = 1'b0;
      rst      = 1'b0;
      step();
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready: got %b, required 1", in_ready); end
   endtask

   task automatic test_single();
      exp_t l;
      vx[0] = 32'h0001_0000;
      vw[0] = 32'h0002_0000;
      l = {32'h0002_8000, 1'b0, 1'b0};
      send_vec(1, 32'h0000_8000, 0, 1'b1, 1'b1, l);
      // Now in cycle T+1 after the accepting edge.
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_t1: out_valid=%b, required 0", out_valid); end
      step();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_t2: out_valid=%b, required 0", out_valid); end
      step();
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_t3: out_valid=%b, required 1", out_valid); end
      collect("single");
   endtask

   task automatic test_patterns();
      exp_t l;
      for (int i = 0; i < 4; i++) begin
         vx[i] = 32'h0000_8000;
         vw[i] = 32'hFFFF_0000;
      end
      l = {32'hFFFE_0000, 1'b0, 1'b0};
      send_vec(4, 32'h0, 0, 1'b1, 1'b1, l);
      collect("four_beat");

      vx[0] = 32'hFFFF_8000;
      vw[0] = 32'h0000_0001;
      l = {32'hFFFF_FFFF, 1'b0, 1'b0};
      send_vec(1, 32'h0, 0, 1'b1, 1'b1, l);
      collect("trunc");

      for (int i = 0; i < 2; i++) begin
         vx[i] = 32'h7FFF_0000;
         vw[i] = 32'h7FFF_0000;
      end
`ifdef NEURON_MAC_SAT_EN
      l = {32'h7FFF_FFFF, 1'b1, 1'b0};
`else
      l = {32'h0002_0000, 1'b0, 1'b0};
`endif
      send_vec(2, 32'h0, 0, 1'b1, 1'b1, l);
      collect("ovf");
   endtask

   task automatic test_len();
      exp_t l;
      for (int i = 0; i < 1024; i++) begin
         vx[i] = FX_ONE;
         vw[i] = FX_ONE;
      end
      l = {32'h0400_0000, 1'b0, 1'b1};
      send_vec(1024, 32'h0, 0, 1'b0, 1'b1, l);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL len_stop: in_ready=%b after beat 1024, required 0", in_ready); end
      collect("len");
   endtask

   task automatic test_gaps();
      exp_t l;
      logic [31:0] r;
      l = '0;
      for (int i = 0; i < 8; i++) begin
         r = $urandom;
         vx[i] = {{8{r[23]}}, r[23:0]};
         r = $urandom;
         vw[i] = {{12{r[19]}}, r[19:0]};
      end
      r = $urandom;
      send_vec(8, {{8{r[23]}}, r[23:0]}, 0, 1'b1, 1'b0, l);
      collect("gapless");
      send_vec(8, {{8{r[23]}}, r[23:0]}, 45, 1'b1, 1'b0, l);
      collect("gapped");
   endtask

   task automatic test_back_to_back();
      exp_t l;
      int   n;
      // out_ready while idle must not create a result.
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_ready: out_valid=%b, required 0", out_valid); end

      vx[0] = 32'h0003_0000;
      vw[0] = 32'h0002_0000;
      l = {32'h0006_0000, 1'b0, 1'b0};
      send_vec(1, 32'h0, 0, 1'b1, 1'b1, l);
      n = 0;
      while (!out_valid && n < 40) begin step(); n++; end
      in_valid = 1'b1;
      in_x     = 32'h0100_0000;
      in_w     = 32'h0100_0000;
      in_last  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         total++;
         if (out_phase !== 32'h0006_0000 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_out: cycle %0d phase=%h valid=%b, required 00060000/1", c, out_phase, out_valid);
         end
         total++;
         if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready: cycle %0d got %b, required 0", c, in_ready); end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      collect("stall");
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b after handshake, required 1", in_ready); end

      vx[0] = 32'hFFFE_0000;
      vw[0] = 32'h0001_8000;
      l = {32'hFFFD_4000, 1'b0, 1'b0};
      send_vec(1, 32'h0000_4000, 0, 1'b1, 1'b1, l);
      collect("b2b");
   endtask

   task automatic test_reset_mid();
      exp_t l;
      int   n;
      in_valid = 1'b1;
      in_x     = 32'h0005_0000;
      in_w     = 32'h0005_0000;
      bias     = 32'h0007_0000;
      in_last  = 1'b0;
      step();
      step();
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b, required 0", in_ready); end
      rst = 1'b0;
      step();
      vx[0] = FX_ONE;
      vw[0] = FX_ONE;
      l = {32'h0001_0000, 1'b0, 1'b0};
      send_vec(1, 32'h0, 0, 1'b1, 1'b1, l);
      collect("after_rst");

      // Reset while a result is pending in OUT discards it.
      vx[0] = 32'h0004_0000;
      l = {32'h0004_0000, 1'b0, 1'b0};
      send_vec(1, 32'h0, 0, 1'b1, 1'b1, l);
      n = 0;
      while (!out_valid && n < 40) begin step(); n++; end
      rst = 1'b1;
      step();
      rst = 1'b0;
      void'(sb.pop_back());
      total++;
      if (out_valid !== 1'b0 || out_phase !== 32'h0) begin
         bad++;
         $display("FAIL out_rst: valid=%b phase=%h, required 0/00000000", out_valid, out_phase);
      end
      step();
      vx[0] = 32'h0002_0000;
      vw[0] = 32'h0002_0000;
      l = {32'h0004_0000, 1'b0, 1'b0};
      send_vec(1, 32'h0, 0, 1'b1, 1'b1, l);
      collect("after_out_rst");
   endtask

   initial begin
      test_reset();
      test_single();
      test_patterns();
      test_len();
      test_gaps();
      test_back_to_back();
      test_reset_mid();
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL sb_left: %0d entries pending, required 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
